i2si_stream_ctrl: RTL and testbench

Controller for the I2S-in receive path. Sequences the deserializer enable so capture always starts on a left-channel frame boundary, and buffers completed stereo frames in a small FIFO. Delivers frames downstream over a valid/ready handshake and flags overruns. Sits between the register file (rf_i2si_*), the i2si deserializer and the audio sample consumer.

---
 rtl/i2si_pkg.sv | 23 ++
 rtl/i2si_stream_ctrl_if.sv | 19 +
 rtl/i2si_frame_fifo.sv | 67 ++++++
 rtl/i2si_stream_ctrl.sv | 127 ++++++++++++
 tb/tb_i2si_stream_ctrl.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/i2si_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | i2si_pkg : shared types and constants for the I2S-in receive path           |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package i2si_pkg;

  localparam int I2SI_DW = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } i2si_state_e;

  typedef struct packed {
    logic [I2SI_DW-1:0] lft;
    logic [I2SI_DW-1:0] rgt;
  } i2si_frame_t;

endpackage
`default_nettype wire

// File: rtl/i2si_stream_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | i2si_stream_ctrl_if : stereo sample stream (valid/ready) toward consumer    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface i2si_stream_ctrl_if
  import i2si_pkg::*;
#(
  parameter int DW = I2SI_DW
);
  logic [DW-1:0] smp_lft;
  logic [DW-1:0] smp_rgt;
  logic          smp_vld;
  logic          smp_rdy;

  modport master (output smp_lft, output smp_rgt, output smp_vld, input  smp_rdy);
  modport slave  (input  smp_lft, input  smp_rgt, input  smp_vld, output smp_rdy);
endinterface
`default_nettype wire

// File: rtl/i2si_frame_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | i2si_frame_fifo : first-word fall-through stereo frame FIFO                |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module i2si_frame_fifo
  import i2si_pkg::*;
#(
  parameter int DW    = I2SI_DW,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [2*DW-1:0]         wdata,
  output logic [2*DW-1:0]         rdata,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
);
  localparam int           AW       = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

  logic [2*DW-1:0] mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     lvl_q, lvl_d;
  logic            wr_en, rd_en;

  assign full  = (lvl_q == LVL_FULL);
  assign empty = (lvl_q == '0);
  assign level = lvl_q;
  // A push into a full FIFO only lands when the head leaves in the same cycle
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    lvl_d    = lvl_q;
    case ({wr_en, rd_en})
      2'b10:   lvl_d = lvl_q + LVL_ONE;
      2'b01:   lvl_d = lvl_q - LVL_ONE;
      default: lvl_d = lvl_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      lvl_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      lvl_q    <= lvl_d;
    end
  end
endmodule
`default_nettype wire

// File: rtl/i2si_stream_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | i2si_stream_ctrl : I2S-in capture sequencing, frame buffering, overrun flag |
// | Option   : I2SI_OVR_CNT_EN adds the saturating dropped-frame counter ovr_cnt|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module i2si_stream_ctrl
  import i2si_pkg::*;
#(
  parameter int DW    = I2SI_DW,
  parameter int DEPTH = 4
`ifdef I2SI_OVR_CNT_EN
  ,
  parameter int CNTW  = 8
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rf_i2si_en,
  input  logic                    rf_i2si_ovr_clr,
  input  logic                    i2si_ws,
  input  logic [DW-1:0]           i2si_lft,
  input  logic [DW-1:0]           i2si_rgt,
  input  logic                    i2si_xfc,
  output logic                    i2si_des_en,
  i2si_stream_ctrl_if.master      smp_if,
  output logic                    i2si_busy,
  output logic                    i2si_ovr,
  output logic [$clog2(DEPTH):0]  fifo_lvl
`ifdef I2SI_OVR_CNT_EN
  ,
  output logic [CNTW-1:0]         ovr_cnt
`endif
);
  logic            ws_s1_q, ws_s1_d, ws_s2_q, ws_s2_d, ws_prev_q, ws_prev_d;
  logic            ws_fall;
  i2si_state_e     state_q, state_d;
  logic            ovr_q, ovr_d;
  logic            push, pop, drop;
  logic            fifo_full, fifo_empty;
  logic [2*DW-1:0] fifo_rdata;

  always_comb begin
    ws_s1_d   = i2si_ws;
    ws_s2_d   = ws_s1_q;
    ws_prev_d = ws_s2_q;
  end
  // Falling ws marks the start of a left word, the only safe capture point
  assign ws_fall = ws_prev_q & ~ws_s2_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rf_i2si_en) state_d = SYNC;
      SYNC:    if (!rf_i2si_en) state_d = IDLE;
               else if (ws_fall) state_d = RUN;
      RUN:     if (!rf_i2si_en) state_d = DRAIN;
      DRAIN:   if (fifo_empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign push  = i2si_xfc & (state_q == RUN);
  assign pop   = smp_if.smp_vld & smp_if.smp_rdy;
  assign drop  = push & fifo_full & ~pop;
  assign ovr_d = drop | (ovr_q & ~rf_i2si_ovr_clr);

  i2si_frame_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({i2si_lft, i2si_rgt}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_lvl)
  );

  assign smp_if.smp_vld = ~fifo_empty;
  assign smp_if.smp_lft = fifo_rdata[2*DW-1:DW];
  assign smp_if.smp_rgt = fifo_rdata[DW-1:0];
  assign i2si_des_en    = (state_q == RUN);
  assign i2si_busy      = (state_q != IDLE);
  assign i2si_ovr       = ovr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ws_s1_q   <= 1'b1;
      ws_s2_q   <= 1'b1;
      ws_prev_q <= 1'b1;
      state_q   <= IDLE;
      ovr_q     <= 1'b0;
    end else begin
      ws_s1_q   <= ws_s1_d;
      ws_s2_q   <= ws_s2_d;
      ws_prev_q <= ws_prev_d;
      state_q   <= state_d;
      ovr_q     <= ovr_d;
    end
  end

`ifdef I2SI_OVR_CNT_EN
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
  logic [CNTW-1:0] ovr_cnt_q, ovr_cnt_d;

  // A drop coinciding with the clear is the first drop of the new window
  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    if (rf_i2si_ovr_clr)
      ovr_cnt_d = drop ? CNT_ONE : '0;
    else if (drop && !(&ovr_cnt_q))
      ovr_cnt_d = ovr_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ovr_cnt_q <= '0;
    else      ovr_cnt_q <= ovr_cnt_d;
  end

  assign ovr_cnt = ovr_cnt_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_i2si_stream_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_i2si_stream_ctrl : directed self-checking bench for i2si_stream_ctrl     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_i2si_stream_ctrl;
  import i2si_pkg::*;

  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rf_i2si_en = 1'b0;
  logic          rf_i2si_ovr_clr = 1'b0;
  logic          i2si_ws = 1'b1;
  logic [DW-1:0] i2si_lft = '0;
  logic [DW-1:0] i2si_rgt = '0;
  logic          i2si_xfc = 1'b0;
  logic          i2si_des_en;
  logic          i2si_busy;
  logic          i2si_ovr;
  logic [2:0]    fifo_lvl;
`ifdef I2SI_OVR_CNT_EN
  logic [7:0]    ovr_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  i2si_stream_ctrl_if #(.DW(DW)) smp_if ();

  i2si_stream_ctrl #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rf_i2si_en      (rf_i2si_en),
    .rf_i2si_ovr_clr (rf_i2si_ovr_clr),
    .i2si_ws         (i2si_ws),
    .i2si_lft        (i2si_lft),
    .i2si_rgt        (i2si_rgt),
    .i2si_xfc        (i2si_xfc),
    .i2si_des_en     (i2si_des_en),
    .smp_if          (smp_if),
    .i2si_busy       (i2si_busy),
    .i2si_ovr        (i2si_ovr),
    .fifo_lvl        (fifo_lvl)
`ifdef I2SI_OVR_CNT_EN
    ,
    .ovr_cnt         (ovr_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic i2si_frame_t head();
    return {smp_if.smp_lft, smp_if.smp_rgt};
  endfunction

  task automatic test_reset();
    smp_if.smp_rdy = 1'b0;
    #2;
    checks++; if (i2si_des_en !== 1'b0) begin errors++; $display("FAIL reset_des_en got %b exp 0", i2si_des_en); end
    checks++; if (smp_if.smp_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b exp 0", smp_if.smp_vld); end
    checks++; if (i2si_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", i2si_busy); end
    checks++; if (i2si_ovr !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b exp 0", i2si_ovr); end
    checks++; if (fifo_lvl !== 3'd0) begin errors++; $display("FAIL reset_lvl got %0d exp 0", fifo_lvl); end
    checks++; if (head() !== 32'h0) begin errors++; $display("FAIL reset_head got %h exp 0", head()); end
`ifdef I2SI_OVR_CNT_EN
    checks++; if (ovr_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", ovr_cnt); end
`endif
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_sync();
    rf_i2si_en = 1'b1;
    step();
    checks++; if (i2si_busy !== 1'b1) begin errors++; $display("FAIL sync_busy got %b exp 1", i2si_busy); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (i2si_des_en !== 1'b0) begin errors++; $display("FAIL sync_hold_des_en[%0d] got %b exp 0", i, i2si_des_en); end
    end
    i2si_ws = 1'b0;
    step();
    checks++; if (i2si_des_en !== 1'b0) begin errors++; $display("FAIL sync_edge1 got %b exp 0", i2si_des_en); end
    step();
    checks++; if (i2si_des_en !== 1'b0) begin errors++; $display("FAIL sync_edge2 got %b exp 0", i2si_des_en); end
    step();
    checks++; if (i2si_des_en !== 1'b1) begin errors++; $display("FAIL sync_edge3 got %b exp 1", i2si_des_en); end
  endtask

  task automatic test_stream();
    i2si_frame_t fr [2];
    fr[0] = 32'hAAAA_FFFF;
    fr[1] = 32'h1478_A3B9;
    smp_if.smp_rdy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      {i2si_lft, i2si_rgt} = fr[i];
      i2si_xfc = 1'b1;
      checks++; if (smp_if.smp_vld !== 1'b0) begin errors++; $display("FAIL stream_pre_vld[%0d] got %b exp 0", i, smp_if.smp_vld); end
      step();
      i2si_xfc = 1'b0;
      checks++; if (smp_if.smp_vld !== 1'b1) begin errors++; $display("FAIL stream_vld[%0d] got %b exp 1", i, smp_if.smp_vld); end
      checks++; if (head() !== fr[i]) begin errors++; $display("FAIL stream_head[%0d] got %h exp %h", i, head(), fr[i]); end
      step();
      checks++; if (smp_if.smp_vld !== 1'b0) begin errors++; $display("FAIL stream_post_vld[%0d] got %b exp 0", i, smp_if.smp_vld); end
    end
    smp_if.smp_rdy = 1'b0;
  endtask

  task automatic test_overflow();
    i2si_frame_t fr [5];
    logic [2:0]  exp_lvl [5];
    logic        exp_ovr [5];
    fr      = '{32'hAAAA_FFFF, 32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888};
    exp_lvl = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    exp_ovr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    smp_if.smp_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      {i2si_lft, i2si_rgt} = fr[i];
      i2si_xfc = 1'b1;
      step();
      checks++; if (fifo_lvl !== exp_lvl[i]) begin errors++; $display("FAIL ovf_lvl[%0d] got %0d exp %0d", i, fifo_lvl, exp_lvl[i]); end
      checks++; if (i2si_ovr !== exp_ovr[i]) begin errors++; $display("FAIL ovf_ovr[%0d] got %b exp %b", i, i2si_ovr, exp_ovr[i]); end
    end
    i2si_xfc = 1'b0;
    checks++; if (head() !== 32'hAAAA_FFFF) begin errors++; $display("FAIL ovf_head got %h exp aaaaffff", head()); end
`ifdef I2SI_OVR_CNT_EN
    checks++; if (ovr_cnt !== 8'd1) begin errors++; $display("FAIL ovf_cnt got %0d exp 1", ovr_cnt); end
`endif
  endtask

  task automatic test_full_push_pop();
    rf_i2si_ovr_clr = 1'b1;
    step();
    rf_i2si_ovr_clr = 1'b0;
    checks++; if (i2si_ovr !== 1'b0) begin errors++; $display("FAIL clr_ovr got %b exp 0", i2si_ovr); end
`ifdef I2SI_OVR_CNT_EN
    checks++; if (ovr_cnt !== 8'd0) begin errors++; $display("FAIL clr_cnt got %0d exp 0", ovr_cnt); end
`endif
    {i2si_lft, i2si_rgt} = 32'h9999_0000;
    i2si_xfc = 1'b1;
    smp_if.smp_rdy = 1'b1;
    step();
    i2si_xfc = 1'b0;
    smp_if.smp_rdy = 1'b0;
    checks++; if (fifo_lvl !== 3'd4) begin errors++; $display("FAIL pushpop_lvl got %0d exp 4", fifo_lvl); end
    checks++; if (i2si_ovr !== 1'b0) begin errors++; $display("FAIL pushpop_ovr got %b exp 0", i2si_ovr); end
    checks++; if (head() !== 32'h1111_2222) begin errors++; $display("FAIL pushpop_head got %h exp 11112222", head()); end
    {i2si_lft, i2si_rgt} = 32'hBBBB_CCCC;
    i2si_xfc = 1'b1;
    rf_i2si_ovr_clr = 1'b1;
    step();
    i2si_xfc = 1'b0;
    rf_i2si_ovr_clr = 1'b0;
    checks++; if (i2si_ovr !== 1'b1) begin errors++; $display("FAIL setwins_ovr got %b exp 1", i2si_ovr); end
    checks++; if (fifo_lvl !== 3'd4) begin errors++; $display("FAIL setwins_lvl got %0d exp 4", fifo_lvl); end
    checks++; if (head() !== 32'h1111_2222) begin errors++; $display("FAIL setwins_head got %h exp 11112222", head()); end
`ifdef I2SI_OVR_CNT_EN
    checks++; if (ovr_cnt !== 8'd1) begin errors++; $display("FAIL setwins_cnt got %0d exp 1", ovr_cnt); end
`endif
  endtask

  task automatic test_drain();
    i2si_frame_t fr [3];
    fr = '{32'h3333_4444, 32'h5555_6666, 32'h9999_0000};
    rf_i2si_ovr_clr = 1'b1;
    smp_if.smp_rdy = 1'b1;
    step();
    rf_i2si_ovr_clr = 1'b0;
    smp_if.smp_rdy = 1'b0;
    checks++; if (fifo_lvl !== 3'd3) begin errors++; $display("FAIL drain_start_lvl got %0d exp 3", fifo_lvl); end
    checks++; if (i2si_ovr !== 1'b0) begin errors++; $display("FAIL drain_start_ovr got %b exp 0", i2si_ovr); end
    rf_i2si_en = 1'b0;
    step();
    checks++; if (i2si_des_en !== 1'b0) begin errors++; $display("FAIL drain_des_en got %b exp 0", i2si_des_en); end
    checks++; if (i2si_busy !== 1'b1) begin errors++; $display("FAIL drain_busy got %b exp 1", i2si_busy); end
    {i2si_lft, i2si_rgt} = 32'hDEAD_BEEF;
    i2si_xfc = 1'b1;
    step();
    i2si_xfc = 1'b0;
    checks++; if (fifo_lvl !== 3'd3) begin errors++; $display("FAIL drain_xfc_lvl got %0d exp 3", fifo_lvl); end
    checks++; if (i2si_ovr !== 1'b0) begin errors++; $display("FAIL drain_xfc_ovr got %b exp 0", i2si_ovr); end
    smp_if.smp_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (head() !== fr[i]) begin errors++; $display("FAIL drain_head[%0d] got %h exp %h", i, head(), fr[i]); end
      checks++; if (smp_if.smp_vld !== 1'b1) begin errors++; $display("FAIL drain_vld[%0d] got %b exp 1", i, smp_if.smp_vld); end
      step();
    end
    smp_if.smp_rdy = 1'b0;
    checks++; if (fifo_lvl !== 3'd0) begin errors++; $display("FAIL drain_end_lvl got %0d exp 0", fifo_lvl); end
    step();
    checks++; if (i2si_busy !== 1'b0) begin errors++; $display("FAIL drain_idle_busy got %b exp 0", i2si_busy); end
  endtask

  task automatic test_async_reset();
    rf_i2si_en = 1'b1;
    i2si_ws = 1'b1;
    repeat (3) step();
    i2si_ws = 1'b0;
    repeat (3) step();
    checks++; if (i2si_des_en !== 1'b1) begin errors++; $display("FAIL rerun_des_en got %b exp 1", i2si_des_en); end
    for (int i = 0; i < 5; i++) begin
      {i2si_lft, i2si_rgt} = 32'h0101_0000 + 32'(i);
      i2si_xfc = 1'b1;
      step();
    end
    i2si_xfc = 1'b0;
    checks++; if (fifo_lvl !== 3'd4) begin errors++; $display("FAIL rerun_lvl got %0d exp 4", fifo_lvl); end
    checks++; if (i2si_ovr !== 1'b1) begin errors++; $display("FAIL rerun_ovr got %b exp 1", i2si_ovr); end
    #1;
    rst = 1'b0;
    #1;
    checks++; if (i2si_des_en !== 1'b0) begin errors++; $display("FAIL arst_des_en got %b exp 0", i2si_des_en); end
    checks++; if (i2si_busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %b exp 0", i2si_busy); end
    checks++; if (i2si_ovr !== 1'b0) begin errors++; $display("FAIL arst_ovr got %b exp 0", i2si_ovr); end
    checks++; if (fifo_lvl !== 3'd0) begin errors++; $display("FAIL arst_lvl got %0d exp 0", fifo_lvl); end
    checks++; if (smp_if.smp_vld !== 1'b0) begin errors++; $display("FAIL arst_vld got %b exp 0", smp_if.smp_vld); end
    checks++; if (head() !== 32'h0) begin errors++; $display("FAIL arst_head got %h exp 0", head()); end
`ifdef I2SI_OVR_CNT_EN
    checks++; if (ovr_cnt !== 8'd0) begin errors++; $display("FAIL arst_cnt got %0d exp 0", ovr_cnt); end
`endif
    rf_i2si_en = 1'b0;
    step();
    rst = 1'b1;
    step();
    checks++; if (i2si_busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy got %b exp 0", i2si_busy); end
  endtask

  initial begin
    test_reset();
    test_sync();
    test_stream();
    test_overflow();
    test_full_push_pop();
    test_drain();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
